nest_block_checker: RTL and testbench

//  Streaming checker for begin/end keyword nesting in an 8-bit ASCII character stream,
//  one character per accepted cycle. Generalises the single-level block checker:
//  - parametrised depth counter with saturation and overflow flag
//  - optional case sensitivity
//  - valid qualifier and synchronous stream clear
//  - exact whole-word matching

---
 rtl/nest_block_checker.sv | 161 ++++++++++++++++
 tb/tb_nest_block_checker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/nest_block_checker.sv
// nest_block_checker
//   Streaming begin/end nesting checker for an 8-bit ASCII character stream,
//   one character per accepted (in_valid) cycle. Whole words are recognised
//   by a small word FSM and committed to a saturating depth counter when a
//   delimiter arrives. All outputs are registered.
//
// Parameters
//   DEPTH_W    width of the nesting counter (MAX_DEPTH = 2**DEPTH_W-1)
//   CASE_SENS  0: keywords match in any case, 1: lowercase only
//   WS_DELIM   0: only space delimits, 1: also TAB, LF, CR
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   clr            synchronous clear of all state, wins over in_valid
//   in_valid       'in' carries a character this cycle
//   in             ASCII character
//   result         1 = stream so far is balanced and error-free
//   depth          committed nesting depth
//   err_underflow  sticky: "end" committed at depth 0
//   err_overflow   sticky: "begin" committed at MAX_DEPTH
module nest_block_checker #(
  parameter int unsigned DEPTH_W   = 8,
  parameter bit          CASE_SENS = 1'b0,
  parameter bit          WS_DELIM  = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               err_underflow,
  output logic               err_overflow
);

  localparam logic [DEPTH_W-1:0] MAX_DEPTH = '1;

  typedef enum logic [3:0] {
    W_IDLE,
    W_B1,
    W_B2,
    W_B3,
    W_B4,
    W_BEGIN,
    W_E1,
    W_E2,
    W_END,
    W_OTHER
  } word_state_e;

  word_state_e        word_q, word_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_u_q, err_u_d;
  logic               err_o_q, err_o_d;
  logic               result_q, result_d;

  logic [7:0]         ch;
  logic               is_delim;
  logic [DEPTH_W:0]   depth_ext;
  logic [DEPTH_W:0]   eff_depth;

  // Optional case folding: A-Z -> a-z.
  always_comb begin
    ch = in;
    if (!CASE_SENS && (in >= 8'h41) && (in <= 8'h5A)) begin
      ch = in | 8'h20;
    end
  end

  assign is_delim = (in == 8'h20) ||
                    (WS_DELIM && ((in == 8'h09) || (in == 8'h0A) || (in == 8'h0D)));

  // Word FSM next state. A delimiter always returns to idle; anything that
  // breaks a keyword prefix (including a trailing char after a full keyword)
  // parks in W_OTHER until the next delimiter.
  always_comb begin
    word_d = W_OTHER;
    if (is_delim) begin
      word_d = W_IDLE;
    end else begin
      unique case (word_q)
        W_IDLE:  word_d = (ch == "b") ? W_B1 : ((ch == "e") ? W_E1 : W_OTHER);
        W_B1:    word_d = (ch == "e") ? W_B2    : W_OTHER;
        W_B2:    word_d = (ch == "g") ? W_B3    : W_OTHER;
        W_B3:    word_d = (ch == "i") ? W_B4    : W_OTHER;
        W_B4:    word_d = (ch == "n") ? W_BEGIN : W_OTHER;
        W_E1:    word_d = (ch == "n") ? W_E2    : W_OTHER;
        W_E2:    word_d = (ch == "d") ? W_END   : W_OTHER;
        default: word_d = W_OTHER;
      endcase
    end
  end

  // Commit on delimiter. Depth is frozen once either error flag is set.
  always_comb begin
    depth_ext = {1'b0, depth_q};
    depth_d   = depth_q;
    err_u_d   = err_u_q;
    err_o_d   = err_o_q;
    if (is_delim) begin
      if (word_q == W_BEGIN) begin
        if (depth_q == MAX_DEPTH) begin
          err_o_d = 1'b1;
        end else if (!err_u_q && !err_o_q) begin
          depth_ext = {1'b0, depth_q} + 1'b1;
          depth_d   = depth_ext[DEPTH_W-1:0];
        end
      end else if (word_q == W_END) begin
        if (depth_q == '0) begin
          err_u_d = 1'b1;
        end else if (!err_u_q && !err_o_q) begin
          depth_ext = {1'b0, depth_q} - 1'b1;
          depth_d   = depth_ext[DEPTH_W-1:0];
        end
      end
    end
  end

  // A pending keyword counts as if it had just been terminated. The extra
  // width keeps MAX_DEPTH+1 and 0-1 distinct from zero.
  always_comb begin
    eff_depth = {1'b0, depth_d};
    if (word_d == W_BEGIN) begin
      eff_depth = {1'b0, depth_d} + 1'b1;
    end else if (word_d == W_END) begin
      eff_depth = {1'b0, depth_d} - 1'b1;
    end
    result_d = !err_u_d && !err_o_d && (eff_depth == '0) &&
               !((word_d == W_END) && (depth_d == '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q   <= W_IDLE;
      depth_q  <= '0;
      err_u_q  <= 1'b0;
      err_o_q  <= 1'b0;
      result_q <= 1'b1;
    end else if (clr) begin
      word_q   <= W_IDLE;
      depth_q  <= '0;
      err_u_q  <= 1'b0;
      err_o_q  <= 1'b0;
      result_q <= 1'b1;
    end else if (in_valid) begin
      word_q   <= word_d;
      depth_q  <= depth_d;
      err_u_q  <= err_u_d;
      err_o_q  <= err_o_d;
      result_q <= result_d;
    end
  end

  assign result        = result_q;
  assign depth         = depth_q;
  assign err_underflow = err_u_q;
  assign err_overflow  = err_o_q;

endmodule

// File: tb/tb_nest_block_checker.sv
// Self-checking bench for nest_block_checker. Three instances share the
// stimulus: default parameters (table-driven vectors), DEPTH_W=2 (overflow),
// and CASE_SENS=1/WS_DELIM=1 (case and whitespace options).
module tb_nest_block_checker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_ch;

  logic       r1, u1, o1;
  logic [7:0] d1;
  logic       r2, u2, o2;
  logic [1:0] d2;
  logic       r3, u3, o3;
  logic [7:0] d3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nest_block_checker #(.DEPTH_W(8), .CASE_SENS(1'b0), .WS_DELIM(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .result(r1), .depth(d1), .err_underflow(u1), .err_overflow(o1));

  nest_block_checker #(.DEPTH_W(2), .CASE_SENS(1'b0), .WS_DELIM(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .result(r2), .depth(d2), .err_underflow(u2), .err_overflow(o2));

  nest_block_checker #(.DEPTH_W(8), .CASE_SENS(1'b1), .WS_DELIM(1'b1)) dut3 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .result(r3), .depth(d3), .err_underflow(u3), .err_overflow(o3));

  typedef struct {
    logic       c;
    logic       v;
    logic [7:0] ch;
    logic       res;
    logic [7:0] dep;
    logic       eu;
    logic       eo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic v, input logic [7:0] ch,
                     input logic res, input logic [7:0] dep, input logic eu, input logic eo);
    vec_t x;
    x.c = c; x.v = v; x.ch = ch; x.res = res; x.dep = dep; x.eu = eu; x.eo = eo;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One accepted-or-idle cycle: drive at negedge, sample 1ns after posedge.
  task automatic send(input logic c, input logic v, input logic [7:0] ch);
    @(negedge clk);
    clr = c; in_valid = v; in_ch = ch;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_ch = 8'h00;

    // "begin end "
    add(1,1,"x",1,0,0,0);
    add(0,1,"b",1,0,0,0); add(0,1,"e",1,0,0,0); add(0,1,"g",1,0,0,0);
    add(0,1,"i",1,0,0,0); add(0,1,"n",0,0,0,0); add(0,1," ",0,1,0,0);
    add(0,1,"e",0,1,0,0); add(0,1,"n",0,1,0,0); add(0,1,"d",1,1,0,0);
    add(0,1," ",1,0,0,0);
    // "end " at start, then "begin end " stays in error
    add(1,1,"x",1,0,0,0);
    add(0,1,"e",1,0,0,0); add(0,1,"n",1,0,0,0); add(0,1,"d",0,0,0,0);
    add(0,1," ",0,0,1,0);
    add(0,1,"b",0,0,1,0); add(0,1,"e",0,0,1,0); add(0,1,"g",0,0,1,0);
    add(0,1,"i",0,0,1,0); add(0,1,"n",0,0,1,0); add(0,1," ",0,0,1,0);
    add(0,1,"e",0,0,1,0); add(0,1,"n",0,0,1,0); add(0,1,"d",0,0,1,0);
    add(0,1," ",0,0,1,0);
    // "BEGIN  begins end"
    add(1,1,"x",1,0,0,0);
    add(0,1,"B",1,0,0,0); add(0,1,"E",1,0,0,0); add(0,1,"G",1,0,0,0);
    add(0,1,"I",1,0,0,0); add(0,1,"N",0,0,0,0); add(0,1," ",0,1,0,0);
    add(0,1," ",0,1,0,0);
    add(0,1,"b",0,1,0,0); add(0,1,"e",0,1,0,0); add(0,1,"g",0,1,0,0);
    add(0,1,"i",0,1,0,0); add(0,1,"n",0,1,0,0); add(0,1,"s",0,1,0,0);
    add(0,1," ",0,1,0,0);
    add(0,1,"e",0,1,0,0); add(0,1,"n",0,1,0,0); add(0,1,"d",1,1,0,0);
    // "begin " with in_valid toggling; idle cycles carry junk and must hold
    add(1,1,"x",1,0,0,0);
    add(0,1,"b",1,0,0,0); add(0,0,"n",1,0,0,0); add(0,1,"e",1,0,0,0);
    add(0,0," ",1,0,0,0); add(0,1,"g",1,0,0,0); add(0,0,"x",1,0,0,0);
    add(0,1,"i",1,0,0,0); add(0,0,"x",1,0,0,0); add(0,1,"n",0,0,0,0);
    add(0,0,"x",0,0,0,0); add(0,1," ",0,1,0,0); add(0,0," ",0,1,0,0);
    // clr mid-word: "beg", clr on 'i', then "in "
    add(1,1,"x",1,0,0,0);
    add(0,1,"b",1,0,0,0); add(0,1,"e",1,0,0,0); add(0,1,"g",1,0,0,0);
    add(1,1,"i",1,0,0,0);
    add(0,1,"i",1,0,0,0); add(0,1,"n",1,0,0,0); add(0,1," ",1,0,0,0);
    // TAB is not a delimiter with WS_DELIM=0: "end\t" becomes a plain word
    add(1,1,"x",1,0,0,0);
    add(0,1,"e",1,0,0,0); add(0,1,"n",1,0,0,0); add(0,1,"d",0,0,0,0);
    add(0,1,8'h09,1,0,0,0); add(0,1," ",1,0,0,0);

    // Reset values while reset_n is held low
    repeat (2) @(negedge clk);
    chk("rst_result", {31'd0, r1}, 32'd1);
    chk("rst_depth",  {24'd0, d1}, 32'd0);
    chk("rst_eu",     {31'd0, u1}, 32'd0);
    chk("rst_eo",     {31'd0, o1}, 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].c, vecs[i].v, vecs[i].ch);
      chk($sformatf("vec%0d_result", i), {31'd0, r1}, {31'd0, vecs[i].res});
      chk($sformatf("vec%0d_depth", i),  {24'd0, d1}, {24'd0, vecs[i].dep});
      chk($sformatf("vec%0d_eu", i),     {31'd0, u1}, {31'd0, vecs[i].eu});
      chk($sformatf("vec%0d_eo", i),     {31'd0, o1}, {31'd0, vecs[i].eo});
      $display("vec %0d ch=%02h clr=%0b vld=%0b -> result=%0b depth=%0d eu=%0b eo=%0b",
               i, vecs[i].ch, vecs[i].c, vecs[i].v, r1, d1, u1, o1);
    end

    // DEPTH_W=2: four "begin " -> depth 1,2,3 then overflow with depth held at 3
    send(1, 1, "x");
    for (int k = 0; k < 4; k++) begin
      send(0, 1, "b"); send(0, 1, "e"); send(0, 1, "g"); send(0, 1, "i"); send(0, 1, "n");
      chk($sformatf("ovf%0d_pending_result", k), {31'd0, r2}, 32'd0);
      send(0, 1, " ");
      chk($sformatf("ovf%0d_depth", k), {30'd0, d2}, (k < 3) ? k + 1 : 3);
      chk($sformatf("ovf%0d_eo", k), {31'd0, o2}, (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("ovf%0d_result", k), {31'd0, r2}, 32'd0);
      $display("ovf begin %0d -> result=%0b depth=%0d eo=%0b", k, r2, d2, o2);
    end
    send(0, 1, "e"); send(0, 1, "n"); send(0, 1, "d"); send(0, 1, " ");
    chk("ovf_frozen_depth", {30'd0, d2}, 32'd3);
    chk("ovf_frozen_result", {31'd0, r2}, 32'd0);
    send(1, 0, "x");
    chk("ovf_clr_eo", {31'd0, o2}, 32'd0);
    chk("ovf_clr_depth", {30'd0, d2}, 32'd0);
    chk("ovf_clr_result", {31'd0, r2}, 32'd1);
    $display("ovf end/clr -> result=%0b depth=%0d eo=%0b", r2, d2, o2);

    // CASE_SENS=1, WS_DELIM=1
    send(1, 1, "x");
    send(0, 1, "B"); send(0, 1, "E"); send(0, 1, "G"); send(0, 1, "I"); send(0, 1, "N");
    chk("cs_upper_result", {31'd0, r3}, 32'd1);
    send(0, 1, " ");
    chk("cs_upper_depth", {24'd0, d3}, 32'd0);
    send(0, 1, "b"); send(0, 1, "e"); send(0, 1, "g"); send(0, 1, "i"); send(0, 1, "n");
    send(0, 1, 8'h09);
    chk("cs_tab_depth", {24'd0, d3}, 32'd1);
    chk("cs_tab_result", {31'd0, r3}, 32'd0);
    send(0, 1, "e"); send(0, 1, "n"); send(0, 1, "d");
    send(0, 1, 8'h0A);
    chk("cs_lf_depth", {24'd0, d3}, 32'd0);
    chk("cs_lf_result", {31'd0, r3}, 32'd1);
    $display("case/ws sequence -> result=%0b depth=%0d eu=%0b", r3, d3, u3);

    // Asynchronous reset mid-word discards the partial word
    send(1, 1, "x");
    send(0, 1, "b"); send(0, 1, "e"); send(0, 1, "g"); send(0, 1, "i"); send(0, 1, "n");
    send(0, 1, " ");
    send(0, 1, "b"); send(0, 1, "e"); send(0, 1, "g");
    chk("arst_pre_depth", {24'd0, d1}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_depth", {24'd0, d1}, 32'd0);
    chk("arst_result", {31'd0, r1}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    send(0, 1, "i"); send(0, 1, "n");
    chk("arst_in_result", {31'd0, r1}, 32'd1);
    send(0, 1, " ");
    chk("arst_space_depth", {24'd0, d1}, 32'd0);
    chk("arst_space_result", {31'd0, r1}, 32'd1);
    $display("async reset mid-word -> result=%0b depth=%0d", r1, d1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
